// File: rtl/mips_prog_loader.sv
// Program loader for the MIPS32 instruction memory.
// Accepts a byte stream (valid/ready), assembles big-endian 32-bit words,
// writes them to consecutive word addresses from 0, verifies an XOR checksum
// and then releases the core through cpu_run.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle pulse, (re)starts a load from any state
//   in_data/in_valid    stream byte and its valid
//   in_ready            loader accepts a byte this cycle
//   mem_we/mem_addr/mem_wdata  one-cycle instruction-memory write
//   busy                load in progress
//   load_done/cpu_run   load finished with a good checksum
//   load_err            length or checksum failure, sticky until start
module mips_prog_loader #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              load_done,
    output logic              load_err,
    output logic              cpu_run
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_WORD, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] len;
    logic [15:0] word_cnt;
    logic [1:0]  byte_cnt;
    logic [23:0] shift;
    logic [7:0]  xsum;
    logic        accept;
    logic [15:0] len_now;
    logic        active_nxt;

    // Bytes presented on a start cycle are dropped.
    assign accept     = in_valid && in_ready && !start;
    assign len_now    = {len[15:8], in_data};
    assign active_nxt = (state_nxt == S_HDR0) || (state_nxt == S_HDR1) ||
                        (state_nxt == S_WORD) || (state_nxt == S_CHK);

    // Next-state decision; the register block below derives outputs from it
    // so that every status output is registered yet tracks the state exactly.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = S_HDR0;
        end else if (accept) begin
            case (state)
                S_HDR0: state_nxt = S_HDR1;
                S_HDR1: begin
                    if (len_now > MAX_LEN)   state_nxt = S_ERR;
                    else if (len_now == 16'd0) state_nxt = S_CHK;
                    else                      state_nxt = S_WORD;
                end
                S_WORD: begin
                    if (byte_cnt == 2'd3 && (word_cnt + 16'd1) == len)
                        state_nxt = S_CHK;
                end
                S_CHK:  state_nxt = (in_data == xsum) ? S_DONE : S_ERR;
                default: state_nxt = state;
            endcase
        end
    end

    // State, counters, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            cpu_run   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            len       <= '0;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            shift     <= '0;
            xsum      <= '0;
        end else begin
            state     <= state_nxt;
            in_ready  <= active_nxt;
            busy      <= active_nxt;
            load_done <= (state_nxt == S_DONE);
            cpu_run   <= (state_nxt == S_DONE);
            load_err  <= (state_nxt == S_ERR);
            mem_we    <= accept && (state == S_WORD) && (byte_cnt == 2'd3);

            if (start) begin
                mem_addr <= '0;
                word_cnt <= '0;
                byte_cnt <= '0;
                xsum     <= '0;
            end else begin
                // Address moves on the edge that closes the write cycle.
                if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);
                if (accept) begin
                    if (state != S_CHK) xsum <= xsum ^ in_data;
                    case (state)
                        S_HDR0: len[15:8] <= in_data;
                        S_HDR1: len[7:0]  <= in_data;
                        S_WORD: begin
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3) begin
                                mem_wdata <= {shift, in_data};
                                word_cnt  <= word_cnt + 16'd1;
                            end else begin
                                shift <= {shift[15:0], in_data};
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed bench for mips_prog_loader: a stream-level model predicts the
// writes and final status of each load; a per-cycle monitor checks writes.
module tb_mips_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        load_done;
    logic        load_err;
    logic        cpu_run;

    mips_prog_loader #(.ADDR_W(10), .MAX_WORDS(1024)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .load_done(load_done), .load_err(load_err), .cpu_run(cpu_run)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] seen_d[$];

    logic [7:0] nom[$] = '{8'h00, 8'h03, 8'h28, 8'h01, 8'h00, 8'h0A, 8'h28,
                           8'h02, 8'h00, 8'h14, 8'hFC, 8'h00, 8'h00, 8'h00, 8'hE2};
    logic [7:0] bad[$];
    logic [7:0] zero_len[$] = '{8'h00, 8'h00, 8'h00};
    logic [7:0] oversize[$] = '{8'h04, 8'h01};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Stream-level model: queues the writes produced by the first n bytes and
    // returns the resulting status (0 still loading, 1 done, 2 error).
    function automatic int model(input logic [7:0] b[$], input int n);
        int         len;
        logic [7:0] x;
        wr_t        w;
        if (n < 2) return 0;
        len = int'({b[0], b[1]});
        if (len > 1024) return 2;
        for (int k = 0; k < len && 6 + 4 * k <= n; k++) begin
            w.a = 10'(k);
            w.d = {b[2+4*k], b[3+4*k], b[4+4*k], b[5+4*k]};
            exp_q.push_back(w);
        end
        if (n < 3 + 4 * len) return 0;
        x = 8'h00;
        for (int i = 0; i < 2 + 4 * len; i++) x = x ^ b[i];
        return (x == b[2+4*len]) ? 1 : 2;
    endfunction

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (mem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write addr=%h data=%h required=no write",
                             mem_addr, mem_wdata);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(e.a));
                    chk("wr_data", mem_wdata, e.d);
                    seen_d.push_back(mem_wdata);
                end
            end
            chk("run_eq_done", 32'(cpu_run), 32'(load_done));
        end
    end

    // All driving tasks start and end 1 time unit after a rising edge.
    task automatic pulse_start();
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b[$], input int n, input bit stall);
        int t;
        for (int i = 0; i < n; i++) begin
            if (stall) begin
                while ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            in_data  = b[i];
            in_valid = 1'b1;
            t = 0;
            while (in_ready !== 1'b1 && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
            if (in_ready !== 1'b1) begin
                chk("ready_timeout", 32'(in_ready), 32'd1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic check_status(input string name, input int st);
        chk({name, "_done"},  32'(load_done), 32'(st == 1));
        chk({name, "_err"},   32'(load_err),  32'(st == 2));
        chk({name, "_run"},   32'(cpu_run),   32'(st == 1));
        chk({name, "_ready"}, 32'(in_ready),  32'(st == 0));
        chk({name, "_busy"},  32'(busy),      32'(st == 0));
    endtask

    task automatic run_case(input string name, input logic [7:0] b[$], input bit stall);
        int st;
        pulse_start();
        st = model(b, b.size());
        send(b, b.size(), stall);
        check_status(name, st);
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_drain"}, 32'(exp_q.size()), 32'd0);
        check_status({name, "_hold"}, st);
    endtask

    initial begin
        int st;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        bad = nom;
        bad[14] = 8'hE3;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_we",    32'(mem_we),   32'd0);
        chk("rst_busy",  32'(busy),     32'd0);
        chk("rst_done",  32'(load_done), 32'd0);
        chk("rst_err",   32'(load_err), 32'd0);
        chk("rst_run",   32'(cpu_run),  32'd0);
        chk("rst_addr",  32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata,     32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_ready", 32'(in_ready), 32'd0);

        // Pin the model against hand-computed nominal words.
        st = model(nom, 15);
        chk("model_status", 32'(st), 32'd1);
        chk("model_nwords", 32'(exp_q.size()), 32'd3);
        if (exp_q.size() == 3) begin
            chk("model_w0", exp_q[0].d, 32'h2801000A);
            chk("model_w2", exp_q[2].d, 32'hFC000000);
        end
        exp_q.delete();

        // Nominal load with literal write pins.
        seen_d.delete();
        run_case("nominal", nom, 1'b0);
        chk("nom_nwrites", 32'(seen_d.size()), 32'd3);
        if (seen_d.size() == 3) begin
            chk("nom_w0", seen_d[0], 32'h2801000A);
            chk("nom_w1", seen_d[1], 32'h28020014);
            chk("nom_w2", seen_d[2], 32'hFC000000);
        end

        run_case("badsum", bad, 1'b0);
        chk("badsum_err_lit", 32'(load_err), 32'd1);

        seen_d.delete();
        run_case("zerolen", zero_len, 1'b0);
        chk("zerolen_nwrites", 32'(seen_d.size()), 32'd0);

        seen_d.delete();
        run_case("oversize", oversize, 1'b0);
        chk("oversize_nwrites", 32'(seen_d.size()), 32'd0);

        run_case("stall", nom, 1'b1);

        // Restart after 6 bytes: the word-0 write is pending on the start cycle.
        pulse_start();
        st = model(nom, 6);
        send(nom, 6, 1'b0);
        pulse_start();
        st = model(nom, 15);
        send(nom, 15, 1'b0);
        check_status("restart", st);
        repeat (3) @(posedge clk);
        #1;
        chk("restart_drain", 32'(exp_q.size()), 32'd0);

        // Reset during word 2 (after 8 bytes): only word 0 was written.
        pulse_start();
        st = model(nom, 8);
        send(nom, 8, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(in_ready), 32'd0);
        chk("midrst_busy",  32'(busy),     32'd0);
        chk("midrst_we",    32'(mem_we),   32'd0);
        chk("midrst_addr",  32'(mem_addr), 32'd0);
        chk("midrst_wdata", mem_wdata,     32'd0);
        chk("midrst_run",   32'(cpu_run),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_drain", 32'(exp_q.size()), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (5) @(posedge clk);
        #1;
        chk("postrst_ready", 32'(in_ready), 32'd0);
        chk("postrst_run",   32'(cpu_run),  32'd0);
        in_valid = 1'b0;

        run_case("reload", nom, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_prog_loader.md
# mips_prog_loader

Program loader sitting directly upstream of the MIPS32 core's instruction memory. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes them to consecutive memory addresses starting at 0, checks an XOR checksum, and then asserts a run enable that releases the core from its hold. This replaces direct testbench preloading of `mem[]` with a realistic boot path.

## Interface
- `ADDR_W`, 10, instruction-memory word-address width
- `MAX_WORDS`, 1024, largest accepted program length in words; must be ≤ 2^ADDR_W

- `clk`  in  1  single system clock, rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins a new load from any state
- `in_data`  in  8  stream byte
- `in_valid`  in  1  `in_data` is valid
- `in_ready`  out  1  loader accepts a byte this cycle
- `mem_we`  out  1  instruction-memory write strobe, one cycle per word
- `mem_addr`  out  ADDR_W  word address for the write
- `mem_wdata`  out  32  assembled instruction word
- `busy`  out  1  load in progress
- `load_done`  out  1  load completed with a good checksum (level)
- `load_err`  out  1  length or checksum failure (level, sticky until `start`)
- `cpu_run`  out  1  core release; equals `load_done`

## Operation
- Stream format: `LEN[15:8]`, `LEN[7:0]`, then LEN words of 4 bytes each (MSB first), then one checksum byte.
- The checksum byte equals the XOR of all preceding bytes, header included.
- A byte is accepted on a rising edge where `in_valid && in_ready`.
- FSM states:
  - IDLE: ready low; `start` → HDR0.
  - HDR0: accept LEN high byte → HDR1.
  - HDR1: accept LEN low byte. If LEN > MAX_WORDS → ERR. If LEN = 0 → CHK. Otherwise → WORD.
  - WORD: accept bytes 0..3 of each word. After byte 3 is accepted, a write is issued. After the LEN-th word → CHK.
  - CHK: accept the checksum byte. Match → DONE; mismatch → ERR.
  - DONE: `load_done` and `cpu_run` high; ready low.
  - ERR: `load_err` high; ready low.
- `in_ready` is high exactly in HDR0, HDR1, WORD and CHK.
- `busy` is high in HDR0 through CHK.
- `start` in any state, including mid-load, restarts the load: state → HDR0, the address counter, byte counter and running XOR are cleared, and `load_done`, `cpu_run` and `load_err` drop.
- Any byte on the `start` cycle is ignored.
- Word address counter: starts at 0 and increments by 1 after each write. It never wraps, because of the MAX_WORDS check.
- Memory contents beyond LEN are not touched.
- The running XOR is 8-bit and includes every accepted byte except the checksum byte itself.

## Timing
- Reset values:
  - state IDLE
  - `in_ready`, `mem_we`, `busy`, `load_done`, `load_err`, `cpu_run` = 0
  - `mem_addr` = 0, `mem_wdata` = 0
- Write timing:
  - `mem_we` is registered. It is high for exactly one cycle, in the cycle after byte 3 of a word is accepted.
  - `mem_addr` and `mem_wdata` are stable in that cycle.
  - `mem_addr` advances on the following edge.
- Throughput:
  - Back-to-back bytes are accepted every cycle, with no bubbles.
  - Worst-case load length is 2 + 4·LEN + 1 accepted bytes.
- `in_valid` low stalls the load with no timeout; all state is held.
- Status timing: `load_done`/`cpu_run` rise in the cycle after the checksum byte is accepted. `load_err` rises in the cycle after the failing byte.
- A write strobe pending when `start` arrives is still completed (`mem_we` pulse in that cycle) before counters clear.
- Asserting `rst` mid-load returns to IDLE immediately. No further writes are issued, and the core stays held.

## Test plan
- Nominal load:
  - Stimulus: `start`, then 00 03 28 01 00 0A 28 02 00 14 FC 00 00 00 E2 on consecutive cycles.
  - Required: three `mem_we` pulses writing addr0=0x2801000A, addr1=0x28020014, addr2=0xFC000000; `cpu_run`=1 one cycle after E2; `load_err`=0.
- Bad checksum: same stream with last byte E3 → three writes occur, `load_err`=1, `cpu_run` stays 0.
- Zero length: stream 00 00 00 → no `mem_we`; DONE after 3 bytes; `cpu_run`=1.
- Oversize: MAX_WORDS=1024, header 04 01 → ERR after second byte; `in_ready`=0; no writes.
- Stalls and restart:
  - Stimulus: nominal stream with `in_valid` toggled randomly → identical writes and final state.
  - Stimulus: `start` pulsed after 6 bytes → address restarts at 0 and a full new stream loads correctly.
- Reset mid-load: `rst` asserted during word 2 → all outputs at reset values the same cycle; no writes until a new `start`.
